// File: rtl/mem_bus_responder.sv
// Memory-port responder for the mips core: 256x8 RAM plus a small GPIO register space.
// Four-phase request/grant handshake, WAIT_CYCLES wait states inserted before each access.
//   state  | meaning
//   IDLE   | waiting for grant_request; latches the transaction
//   WAIT   | counting wait states; a dropped request aborts
//   ACCESS | RAM/GPIO access on the latched values
//   DONE   | grant held until the request drops
module mem_bus_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       grant_request,
  input  logic       rw,
  input  logic [8:0] address,
  input  logic [7:0] data_out,
  output logic       grant_given,
  output logic [7:0] data_in,
  input  logic [7:0] gpio_pins_in,
  output logic [7:0] gpio_pins_out
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       rw_q;
  logic [8:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] sync1, sync2;
  logic [7:0] rd_data;
  logic [7:0] mem [256];

  // RAM is deliberately left out of reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (state == ACCESS && rw_q && !addr_q[8])
      mem[addr_q[7:0]] <= wdata_q;
  end

  always_comb begin
    rd_data = 8'h00;
    if (!addr_q[8])
      rd_data = mem[addr_q[7:0]];
    else if (addr_q[7:0] == 8'h00)
      rd_data = gpio_pins_out;
    else if (addr_q[7:0] == 8'h01)
      rd_data = sync2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= gpio_pins_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      rw_q          <= 1'b0;
      addr_q        <= 9'h000;
      wdata_q       <= 8'h00;
      grant_given   <= 1'b0;
      data_in       <= 8'h00;
      gpio_pins_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_request) begin
            rw_q     <= rw;
            addr_q   <= address;
            wdata_q  <= data_out;
            wait_cnt <= WAIT_INIT;
            state    <= (WAIT_INIT == 4'd0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (!grant_request) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1)
              state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!rw_q)
            data_in <= rd_data;
          else if (addr_q == 9'h100)
            gpio_pins_out <= wdata_q;
          state <= DONE;
        end
        DONE: begin
          // Grant rises one edge after entering DONE; it can only be released once seen.
          if (grant_given && !grant_request) begin
            grant_given <= 1'b0;
            state       <= IDLE;
          end else begin
            grant_given <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (1, 3 and 0 wait states) against a
// transaction-level model of RAM, GPIO registers and input synchronizer latency.
module tb_mem_bus_responder;

  localparam int WC[3] = '{1, 3, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] gpio_in = 8'h3C;
  logic       req[3], rwv[3], gnt[3];
  logic [8:0] addr[3];
  logic [7:0] dout[3], din[3], gout[3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] ram_m[3][256];
  bit         ram_v[3][256];
  logic [7:0] gpio_m[3], last_rd[3];
  logic [7:0] gp_old, gp_new;
  int         gp_chg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .grant_request(req[0]), .rw(rwv[0]), .address(addr[0]),
    .data_out(dout[0]), .grant_given(gnt[0]), .data_in(din[0]),
    .gpio_pins_in(gpio_in), .gpio_pins_out(gout[0]));
  mem_bus_responder #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(reset), .grant_request(req[1]), .rw(rwv[1]), .address(addr[1]),
    .data_out(dout[1]), .grant_given(gnt[1]), .data_in(din[1]),
    .gpio_pins_in(gpio_in), .gpio_pins_out(gout[1]));
  mem_bus_responder #(.WAIT_CYCLES(0)) u2 (
    .clk(clk), .reset(reset), .grant_request(req[2]), .rw(rwv[2]), .address(addr[2]),
    .data_out(dout[2]), .grant_given(gnt[2]), .data_in(din[2]),
    .gpio_pins_in(gpio_in), .gpio_pins_out(gout[2]));

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A synchronized input becomes readable by an access edge at least 3 edges after the change.
  function automatic logic [7:0] exp_rd(input int i, input logic [8:0] a, input int acc);
    if (!a[8]) return ram_m[i][a[7:0]];
    if (a[7:0] == 8'h00) return gpio_m[i];
    if (a[7:0] == 8'h01) return (acc - gp_chg >= 3) ? gp_new : gp_old;
    return 8'h00;
  endfunction

  task automatic model_write(input int i, input logic [8:0] a, input logic [7:0] d);
    if (!a[8]) begin
      ram_m[i][a[7:0]] = d;
      ram_v[i][a[7:0]] = 1'b1;
    end else if (a[7:0] == 8'h00) begin
      gpio_m[i] = d;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      gpio_m[i]  = 8'h00;
      last_rd[i] = 8'h00;
    end
    gp_old = 8'h00;
    gp_new = gpio_in;
    gp_chg = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_grant", 9'(gnt[i]), 9'h0);
      chk("rst_data_in", 9'(din[i]), 9'h0);
      chk("rst_gpio_out", 9'(gout[i]), 9'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_gpio_in(input logic [7:0] v);
    @(posedge clk);
    #2;
    gp_old  = gp_new;
    gp_new  = v;
    gp_chg  = cyc;
    gpio_in = v;
  endtask

  task automatic txn(input int i, input bit w, input logic [8:0] a, input logic [7:0] d,
                     input int hold);
    logic [7:0] exp;
    int acc;
    @(negedge clk);
    req[i] = 1'b1; rwv[i] = w; addr[i] = a; dout[i] = d;
    acc = cyc + 1 + WC[i] + 1;
    exp = exp_rd(i, a, acc);
    for (int k = 0; k < WC[i] + 2; k++) begin
      @(posedge clk); #1;
      chk("grant_early", 9'(gnt[i]), 9'h0);
    end
    @(posedge clk); #1;
    chk("grant_rise", 9'(gnt[i]), 9'h1);
    if (!w) begin
      chk("rd_data", 9'(din[i]), 9'(exp));
      last_rd[i] = exp;
    end else begin
      model_write(i, a, d);
      chk("wr_keeps_data_in", 9'(din[i]), 9'(last_rd[i]));
    end
    chk("gpio_out", 9'(gout[i]), 9'(gpio_m[i]));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("grant_hold", 9'(gnt[i]), 9'h1);
    end
    if (hold > 0) begin
      chk("hold_data_in", 9'(din[i]), 9'(last_rd[i]));
      chk("hold_gpio_out", 9'(gout[i]), 9'(gpio_m[i]));
    end
    @(negedge clk);
    req[i] = 1'b0;
    @(posedge clk); #1;
    chk("grant_fall", 9'(gnt[i]), 9'h0);
  endtask

  task automatic abort_txn(input int i, input logic [8:0] a, input logic [7:0] d, input int after);
    @(negedge clk);
    req[i] = 1'b1; rwv[i] = 1'b1; addr[i] = a; dout[i] = d;
    repeat (after) @(posedge clk);
    @(negedge clk);
    req[i] = 1'b0;
    for (int k = 0; k < WC[i] + 3; k++) begin
      @(posedge clk); #1;
      chk("abort_no_grant", 9'(gnt[i]), 9'h0);
    end
  endtask

  // Reset is raised just after edge E0+phase, i.e. while the DUT sits in the state entered there.
  task automatic rst_mid(input int i, input logic [8:0] a, input logic [7:0] d, input int phase);
    @(negedge clk);
    req[i] = 1'b1; rwv[i] = 1'b1; addr[i] = a; dout[i] = d;
    repeat (phase + 1) @(posedge clk);
    if (phase == WC[i] + 2) begin
      #1;
      chk("grant_before_rst", 9'(gnt[i]), 9'h1);
      #2;
    end else begin
      #3;
    end
    reset = 1'b1;
    req[i] = 1'b0;
    #1;
    chk("rst_mid_grant", 9'(gnt[i]), 9'h0);
    chk("rst_mid_gpio_out", 9'(gout[i]), 9'h0);
    if (phase > WC[i]) model_write(i, a, d);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; rwv[i] = 1'b0; addr[i] = 9'h000; dout[i] = 8'h00;
      for (int j = 0; j < 256; j++) ram_v[i][j] = 1'b0;
    end
    do_reset();

    txn(0, 1'b1, 9'h03C, 8'hA5, 0);
    txn(0, 1'b0, 9'h03C, 8'h00, 0);
    txn(0, 1'b1, 9'h100, 8'h5A, 0);
    txn(0, 1'b0, 9'h100, 8'h00, 0);
    txn(0, 1'b1, 9'h101, 8'hFF, 0);
    txn(0, 1'b0, 9'h1FF, 8'h00, 0);

    set_gpio_in(8'hC3);
    txn(2, 1'b0, 9'h101, 8'h00, 0);
    txn(0, 1'b0, 9'h101, 8'h00, 0);

    txn(1, 1'b1, 9'h020, 8'h77, 0);
    abort_txn(1, 9'h020, 8'h11, 1);
    txn(1, 1'b0, 9'h020, 8'h00, 0);

    txn(0, 1'b0, 9'h03C, 8'h00, 5);
    txn(0, 1'b0, 9'h100, 8'h00, 0);

    txn(0, 1'b1, 9'h100, 8'h5A, 0);
    rst_mid(0, 9'h100, 8'h99, WC[0]);
    txn(0, 1'b0, 9'h100, 8'h00, 0);
    rst_mid(0, 9'h100, 8'h66, WC[0] + 2);
    txn(0, 1'b0, 9'h100, 8'h00, 0);
    txn(2, 1'b1, 9'h100, 8'h42, 0);
    rst_mid(2, 9'h100, 8'h24, WC[2]);
    rst_mid(2, 9'h100, 8'h81, WC[2] + 2);
    txn(2, 1'b0, 9'h100, 8'h00, 0);
    rst_mid(1, 9'h020, 8'h55, WC[1]);
    txn(1, 1'b0, 9'h020, 8'h00, 0);
    rst_mid(2, 9'h010, 8'hE7, WC[2] + 2);
    txn(2, 1'b0, 9'h010, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      int i;
      bit w;
      logic [8:0] a;
      logic [7:0] off;
      i = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) set_gpio_in(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: off = 8'h00;
          1: off = 8'h01;
          default: off = 8'($urandom_range(2, 255));
        endcase
        a = {1'b1, off};
      end else begin
        a = {1'b0, 8'($urandom)};
        if (!w && !ram_v[i][a[7:0]]) w = 1'b1;
      end
      txn(i, w, a, 8'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
